instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 77 +++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: request, ROM and response signals of the instruction fetch unit.
interface instr_fetch_if;
    logic [15:0] req_addr;
    logic        req_valid;
    logic        req_ready;
    logic        flush;
    logic [14:0] rom_addr;
    logic        rom_en;
    logic [15:0] rom_data;
    logic [15:0] rsp_instr;
    logic [15:0] rsp_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    modport master (
        input  req_addr, req_valid, flush, rom_data, rsp_ready,
        output req_ready, rom_addr, rom_en, rsp_instr, rsp_addr, rsp_valid
    );
    modport slave (
        output req_addr, req_valid, flush, rom_data, rsp_ready,
        input  req_ready, rom_addr, rom_en, rsp_instr, rsp_addr, rsp_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: in-order fetch from a synchronous ROM through a BUF_DEPTH response buffer.
// Define IFETCH_OOR_EN to return 16'h0000 without a ROM read for addresses with bit 15 set.
module instr_fetch #(
    parameter int BUF_DEPTH = 2
) (
    input logic clk,
    input logic reset,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    logic [15:0]   mem_instr [BUF_DEPTH];
    logic [15:0]   mem_addr  [BUF_DEPTH];
    logic [AW-1:0] wp, rp, rp_n;
    logic [AW:0]   count, count_pop, count_n;
    logic [AW+1:0] occ;
    logic          run, inflight, inf_oor, oor, pop, accept;
    logic [15:0]   inf_addr, push_instr;
`ifdef IFETCH_OOR_EN
    assign oor = bus.req_addr[15];
`else
    assign oor = 1'b0;
`endif
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign occ           = (AW+2)'(count) + (AW+2)'(inflight);
    assign bus.req_ready = run && !bus.flush && (occ < (AW+2)'(BUF_DEPTH) || pop);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rom_en    = accept && !oor;
    assign bus.rom_addr  = bus.req_addr[14:0];
    assign push_instr    = inf_oor ? 16'h0000 : bus.rom_data;
    assign count_pop     = count - (AW+1)'(pop);
    assign count_n       = count_pop + (AW+1)'(inflight);
    assign rp_n          = rp + AW'(pop);
    // The response registers preload the next head so rsp_* never depend on rom_data combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run           <= 1'b0;
            inflight      <= 1'b0;
            inf_oor       <= 1'b0;
            inf_addr      <= '0;
            count         <= '0;
            wp            <= '0;
            rp            <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_instr <= '0;
            bus.rsp_addr  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_addr[i]  <= '0;
            end
        end else begin
            run <= 1'b1;
            if (bus.flush) begin
                inflight      <= 1'b0;
                count         <= '0;
                wp            <= '0;
                rp            <= '0;
                bus.rsp_valid <= 1'b0;
            end else begin
                inflight <= accept;
                if (accept) begin
                    inf_addr <= bus.req_addr;
                    inf_oor  <= oor;
                end
                if (inflight) begin
                    mem_instr[wp] <= push_instr;
                    mem_addr[wp]  <= inf_addr;
                    wp            <= wp + 1'b1;
                end
                rp            <= rp_n;
                count         <= count_n;
                bus.rsp_valid <= count_n != 0;
                bus.rsp_instr <= count_pop == 0 ? push_instr : mem_instr[rp_n];
                bus.rsp_addr  <= count_pop == 0 ? inf_addr : mem_addr[rp_n];
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a scoreboard monitor checking responses against a ROM model.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0, n_bad = 0, n_pop = 0, cyc = 0, n0, a;
    instr_fetch_if bus ();
    instr_fetch #(.BUF_DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
`ifdef IFETCH_OOR_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif
    function automatic logic [15:0] rom_val(logic [14:0] x);
        return {x[7:0], 8'h00} ^ {1'b0, x} ^ 16'h5A3C;
    endfunction
    function automatic logic [15:0] exp_instr(logic [15:0] x);
        return (OOR && x[15]) ? 16'h0000 : rom_val(x[14:0]);
    endfunction
    always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_val(bus.rom_addr);
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] instr;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    // Handshakes are judged mid-cycle, where inputs and outputs are settled for the coming edge.
    always @(negedge clk) begin
        if (reset || bus.flush) sb.delete();
        else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_pop++;
                if (sb.size() == 0) chk("rsp_unexpected", {bus.rsp_addr, bus.rsp_instr}, 64'hDEAD);
                else begin
                    e = sb.pop_front();
                    chk("rsp_data", {bus.rsp_addr, bus.rsp_instr}, {e.addr, e.instr});
                    chk("rsp_latency", 64'(cyc - e.cyc >= 2), 64'd1);
                end
            end
            if (bus.req_valid && bus.req_ready)
                sb.push_back('{bus.req_addr, exp_instr(bus.req_addr), cyc});
        end
    end
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 16'h0003;
        bus.flush = 1'b0;
        bus.rsp_ready = 1'b0;
        #2;
        chk("reset_state", {bus.rsp_valid, bus.req_ready, bus.rom_en, bus.rsp_instr, bus.rsp_addr}, 64'd0);
        repeat (2) @(posedge clk);
        #3;
        chk("reset_hold", {bus.rsp_valid, bus.req_ready, bus.rom_en, bus.rsp_instr, bus.rsp_addr}, 64'd0);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("ready_before_edge", bus.req_ready, 0);
        cycle();
        chk("ready_after_edge", bus.req_ready, 1);
        // Streaming: first response two cycles after first accept, then one per cycle.
        bus.rsp_ready = 1'b1;
        n0 = n_pop;
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = i < 8;
            bus.req_addr = 16'(i);
            @(negedge clk);
            chk("stream_valid", bus.rsp_valid, 64'(i >= 2 && i < 10));
            cycle();
        end
        chk("stream_count", n_pop - n0, 8);
        // Backpressure
        bus.rsp_ready = 1'b0;
        a = 16'h0020;
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 1'b1;
            bus.req_addr = 16'(a);
            @(negedge clk);
            chk("bp_ready", bus.req_ready, 64'(k < 2));
            if (k >= 2) chk("bp_hold", {bus.rsp_valid, bus.rsp_addr, bus.rsp_instr}, {1'b1, 16'h0020, rom_val(15'h0020)});
            if (bus.req_ready) a++;
            cycle();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        n0 = n_pop;
        repeat (4) cycle();
        chk("bp_drain", n_pop - n0, 2);
        chk("bp_empty", sb.size(), 0);
        // Flush with a buffered and an in-flight fetch
        n0 = n_pop;
        bus.req_valid = 1'b1;
        bus.req_addr = 16'h0010;
        cycle();
        bus.req_addr = 16'h0011;
        cycle();
        bus.flush = 1'b1;
        bus.req_addr = 16'h0100;
        @(negedge clk);
        chk("flush_ready", bus.req_ready, 0);
        cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", bus.rsp_valid, 0);
        chk("post_flush_ready", bus.req_ready, 1);
        cycle();
        bus.req_valid = 1'b0;
        repeat (4) cycle();
        chk("flush_count", n_pop - n0, 1);
        // Flush on a full buffer with simultaneous pop and request
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = 16'h0030;
        cycle();
        bus.req_addr = 16'h0031;
        cycle();
        bus.req_valid = 1'b0;
        repeat (2) cycle();
        chk("full_head", {bus.rsp_valid, bus.rsp_addr}, {1'b1, 16'h0030});
        n0 = n_pop;
        bus.flush = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 16'h0032;
        @(negedge clk);
        chk("full_flush_ready", bus.req_ready, 0);
        cycle();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("full_flush_valid", bus.rsp_valid, 0);
        repeat (3) cycle();
        chk("full_flush_count", n_pop - n0, 0);
        // Asynchronous reset between edges mid-stream
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1;
            bus.req_addr = 16'(16'h0040 + k);
            cycle();
        end
        bus.req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {bus.rsp_valid, bus.req_ready, bus.rsp_addr, bus.rsp_instr}, 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("reset_release_ready", bus.req_ready, 0);
        n0 = n_pop;
        repeat (4) cycle();
        chk("no_stale", {bus.rsp_valid, 32'(n_pop - n0)}, 64'd0);
        // Out-of-range address versus its in-range alias
        n0 = n_pop;
        bus.req_valid = 1'b1;
        bus.req_addr = 16'h8005;
        @(negedge clk);
        chk("oor_rom_en", {bus.rom_en, bus.rom_addr}, {!OOR, 15'h0005});
        cycle();
        bus.req_addr = 16'h0005;
        @(negedge clk);
        chk("alias_rom_en", {bus.rom_en, bus.rom_addr}, {1'b1, 15'h0005});
        cycle();
        bus.req_valid = 1'b0;
        repeat (4) cycle();
        chk("oor_count", n_pop - n0, 2);
        chk("final_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
